jt10_adpcm_rom_fetch: RTL and testbench

Responder side of the ADPCM-A address-counter ROM port. It accepts one read request per `cen` slot (byte address, bank, nibble select, `roe_n`), serves it from a six-entry per-channel byte cache or from the external sample-ROM/SDRAM port through a `cs`/`ok` handshake, and returns the selected 4-bit nibble to the ADPCM-A decoder one `cen` slot later. It sits between the address counter and the decoder. It replaces direct combinational ROM access so that slow memory controllers can be used.

---
 rtl/jt10_adpcm_defs.sv | 26 ++
 rtl/jt10_adpcm_rom_cache.sv | 66 ++++++
 rtl/jt10_adpcm_rom_fetch.sv | 191 +++++++++++++++++++
 tb/tb_jt10_adpcm_rom_fetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt10_adpcm_defs.sv
// Shared definitions for the ADPCM-A ROM fetch path: sizes, FSM states and nibble order.
package jt10_adpcm_defs;

    localparam int unsigned ROM_AW = 25;
    localparam int unsigned NCH    = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_st_e;

    // High nibble is played first: sel=0 picks [7:4]
    localparam logic SEL_HI = 1'b0;

    typedef struct packed {
        logic [ROM_AW-1:0] tag;
        logic [NCH-1:0]    ch;
        logic              sel;
    } miss_t;

    function automatic logic [3:0] pick_nib(input logic [7:0] b, input logic s);
        return (s == SEL_HI) ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/jt10_adpcm_rom_cache.sv
// One-byte-per-channel cache: combinational one-hot lookup, synchronous fill and invalidate.
module jt10_adpcm_rom_cache #(
    parameter int unsigned AW = 25,
    parameter int unsigned N  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  rd_sel_i,
    input  logic [AW-1:0] rd_tag_i,
    output logic          hit_c_o,
    output logic [7:0]    rd_byte_c_o,
    input  logic          wr_en_i,
    input  logic [N-1:0]  wr_sel_i,
    input  logic [AW-1:0] wr_tag_i,
    input  logic [7:0]    wr_byte_i,
    input  logic          inv_en_i,
    input  logic [N-1:0]  inv_sel_i
);

    logic [N-1:0]  valid_q, valid_d;
    logic [AW-1:0] tag_q  [N];
    logic [7:0]    byte_q [N];

    always_comb begin
        valid_d = valid_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (inv_en_i && inv_sel_i[i]) begin
                valid_d[i] = 1'b0;
            end else if (wr_en_i && wr_sel_i[i]) begin
                valid_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload carries no reset; valid_q guards every read
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (wr_en_i && wr_sel_i[i]) begin
                tag_q[i]  <= wr_tag_i;
                byte_q[i] <= wr_byte_i;
            end
        end
    end

    always_comb begin
        hit_c_o     = 1'b0;
        rd_byte_c_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rd_sel_i[i]) begin
                if (valid_q[i] && (tag_q[i] == rd_tag_i)) begin
                    hit_c_o = 1'b1;
                end
                rd_byte_c_o = rd_byte_c_o | byte_q[i];
            end
        end
    end

endmodule

// File: rtl/jt10_adpcm_rom_fetch.sv
// ADPCM-A ROM responder: per-slot capture, cache lookup, deadline-bounded memory fetch.
module jt10_adpcm_rom_fetch #(
    parameter int unsigned ROM_AW = jt10_adpcm_defs::ROM_AW,
    parameter int unsigned NCH    = jt10_adpcm_defs::NCH
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic              cen,
    input  logic [NCH-1:0]    cur_ch,
    input  logic [19:0]       addr_in,
    input  logic [4:0]        bank,
    input  logic              sel,
    input  logic              roe_n,
    input  logic              clr,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_cs,
    input  logic [7:0]        rom_data,
    input  logic              rom_ok,
    output logic [3:0]        data,
    output logic              data_valid,
    output logic              late
);
    import jt10_adpcm_defs::*;

    fetch_st_e         state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              rom_cs_q, rom_cs_d;
    miss_t             miss_q, miss_d;
    logic              pend_q, pend_d;
    logic [3:0]        nib_q, nib_d;
    logic              prev_hit_q, prev_hit_d;
    logic              prev_miss_q, prev_miss_d;
    logic [3:0]        hit_nib_q, hit_nib_d;
    logic [3:0]        data_q, data_d;
    logic              dv_q, dv_d;
    logic              late_q, late_d;

    logic              onehot_c, cap_c, lookup_c, hit_c, hit_eff_c, new_miss_c, wr_en_c;
    logic [7:0]        cbyte_c;
    logic [ROM_AW-1:0] tag_c;

    assign tag_c      = ROM_AW'({bank, addr_in});
    assign onehot_c   = (cur_ch != '0) && ((cur_ch & (cur_ch - NCH'(1))) == '0);
    assign cap_c      = cen && onehot_c;
    assign lookup_c   = cap_c && !roe_n;
    // A restart on this slot must never be served from the stale entry
    assign hit_eff_c  = hit_c && !clr;
    assign new_miss_c = lookup_c && !hit_eff_c;

    jt10_adpcm_rom_cache #(
        .AW (ROM_AW),
        .N  (NCH)
    ) u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_sel_i    (cur_ch),
        .rd_tag_i    (tag_c),
        .hit_c_o     (hit_c),
        .rd_byte_c_o (cbyte_c),
        .wr_en_i     (wr_en_c),
        .wr_sel_i    (miss_q.ch),
        .wr_tag_i    (rom_addr_q),
        .wr_byte_i   (rom_data),
        .inv_en_i    (cap_c && clr),
        .inv_sel_i   (cur_ch)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        rom_cs_d    = rom_cs_q;
        miss_d      = miss_q;
        pend_d      = pend_q;
        nib_d       = nib_q;
        prev_hit_d  = prev_hit_q;
        prev_miss_d = prev_miss_q;
        hit_nib_d   = hit_nib_q;
        data_d      = data_q;
        dv_d        = dv_q;
        late_d      = late_q;
        wr_en_c     = 1'b0;

        if (new_miss_c) begin
            miss_d = '{tag: tag_c, ch: cur_ch, sel: sel};
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d    = ST_REQ;
                    rom_cs_d   = 1'b1;
                    rom_addr_d = miss_q.tag;
                    pend_d     = 1'b0;
                end
            end
            ST_REQ: begin
                // The slot boundary wins over a simultaneous rom_ok
                if (cen) begin
                    state_d  = ST_IDLE;
                    rom_cs_d = 1'b0;
                end else if (rom_ok) begin
                    state_d  = ST_DONE;
                    rom_cs_d = 1'b0;
                    wr_en_c  = 1'b1;
                    nib_d    = pick_nib(rom_data, miss_q.sel);
                end
            end
            ST_DONE: begin
                if (cen) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rom_cs_d = 1'b0;
            end
        endcase

        // After an abort rom_cs spends one clk low before the address may move
        if (new_miss_c) begin
            if (state_q == ST_REQ) begin
                pend_d = 1'b1;
            end else begin
                state_d    = ST_REQ;
                rom_cs_d   = 1'b1;
                rom_addr_d = tag_c;
                pend_d     = 1'b0;
            end
        end

        if (cen) begin
            if (prev_hit_q) begin
                data_d = hit_nib_q;
                dv_d   = 1'b1;
                late_d = 1'b0;
            end else if (prev_miss_q) begin
                dv_d = 1'b1;
                if (state_q == ST_DONE) begin
                    data_d = nib_q;
                    late_d = 1'b0;
                end else begin
                    data_d = 4'h0;
                    late_d = 1'b1;
                end
            end else begin
                dv_d   = 1'b0;
                late_d = 1'b0;
            end
            prev_hit_d  = lookup_c && hit_eff_c;
            prev_miss_d = new_miss_c;
            hit_nib_d   = pick_nib(cbyte_c, sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= '0;
            rom_cs_q    <= 1'b0;
            miss_q      <= '0;
            pend_q      <= 1'b0;
            nib_q       <= '0;
            prev_hit_q  <= 1'b0;
            prev_miss_q <= 1'b0;
            hit_nib_q   <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            rom_cs_q    <= rom_cs_d;
            miss_q      <= miss_d;
            pend_q      <= pend_d;
            nib_q       <= nib_d;
            prev_hit_q  <= prev_hit_d;
            prev_miss_q <= prev_miss_d;
            hit_nib_q   <= hit_nib_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            late_q      <= late_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_cs     = rom_cs_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign late       = late_q;

endmodule

// File: tb/tb_jt10_adpcm_rom_fetch.sv
// Scoreboard bench for the ADPCM-A ROM fetch block against a per-channel last-byte model.
module tb_jt10_adpcm_rom_fetch;

    localparam int unsigned P = 10;

    typedef struct packed {
        logic [3:0] data;
        logic       dv;
        logic       late;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic [5:0]  cur_ch = '0;
    logic [19:0] addr_in = '0;
    logic [4:0]  bank = '0;
    logic        sel = 1'b0;
    logic        roe_n = 1'b1;
    logic        clr = 1'b0;
    logic [24:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data = '0;
    logic        rom_ok = 1'b0;
    logic [3:0]  data;
    logic        data_valid;
    logic        late;

    exp_t        exp_q[$];
    logic [24:0] addr_q[$];
    int          total = 0;
    int          bad = 0;

    bit          mvalid[6];
    logic [24:0] mtag[6];
    logic [7:0]  mbyte[6];
    logic [3:0]  last_data = '0;

    bit          withhold = 1'b0;
    int          fixed_delay = -1;
    bit          ovr_en = 1'b0;
    logic [7:0]  ovr_byte = '0;
    bit          stray_ok = 1'b0;

    jt10_adpcm_rom_fetch dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .cen        (cen),
        .cur_ch     (cur_ch),
        .addr_in    (addr_in),
        .bank       (bank),
        .sel        (sel),
        .roe_n      (roe_n),
        .clr        (clr),
        .rom_addr   (rom_addr),
        .rom_cs     (rom_cs),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .data       (data),
        .data_valid (data_valid),
        .late       (late)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [24:0] a);
        logic [24:0] t;
        t = a * 25'd97 + 25'd13;
        return t[7:0] ^ t[15:8] ^ t[24:17];
    endfunction

    function automatic logic [3:0] nib(input logic [7:0] b, input bit s);
        return s ? b[3:0] : b[7:4];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Memory responder: answers each rom_cs window after a chosen delay
    int cnt = 0;
    bit busy = 1'b0;
    always @(negedge clk) begin
        if (!rom_cs) begin
            busy   = 1'b0;
            rom_ok = stray_ok;
            if (stray_ok) rom_data = 8'hFF;
        end else begin
            if (!busy) begin
                busy = 1'b1;
                cnt  = (fixed_delay < 0) ? int'($urandom_range(0, 6)) : fixed_delay;
            end
            if (!withhold && cnt == 0) begin
                rom_ok   = 1'b1;
                rom_data = ovr_en ? ovr_byte : rom_byte(rom_addr);
            end else begin
                rom_ok = 1'b0;
                if (cnt > 0) cnt--;
            end
        end
    end

    // Output monitor: one expected entry per cen
    exp_t got_e;
    exp_t want_e;
    always @(posedge clk) begin
        if (cen) begin
            #1;
            got_e = '{data: data, dv: data_valid, late: late};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got %h want none", got_e);
            end else begin
                want_e = exp_q.pop_front();
                check("slot_out", 32'(got_e), 32'(want_e));
            end
        end
    end

    // Memory-side monitor: address at each rom_cs rise and stability inside the window
    logic        cs_prev = 1'b0;
    logic [24:0] addr_prev = '0;
    always @(posedge clk) begin
        #1;
        if (rom_cs && !cs_prev) begin
            if (addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cs_unexpected: got addr %h want no request", rom_addr);
            end else begin
                check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
            end
        end else if (rom_cs && cs_prev) begin
            check("addr_stable", 32'(rom_addr), 32'(addr_prev));
        end
        cs_prev   = rom_cs;
        addr_prev = rom_addr;
    end

    task automatic model_reset();
        for (int i = 0; i < 6; i++) mvalid[i] = 1'b0;
        exp_q.delete();
        addr_q.delete();
        last_data = '0;
        exp_q.push_back('{data: 4'h0, dv: 1'b0, late: 1'b0});
    endtask

    task automatic issue(input logic [5:0] ch, input bit rn, input logic [4:0] bk,
                         input logic [19:0] ad, input bit s, input bit cl);
        exp_t        e;
        int          idx;
        bit          oh;
        logic [24:0] tag;
        logic [7:0]  b;
        tag = {bk, ad};
        oh  = (ch != 6'd0) && ((ch & (ch - 6'd1)) == 6'd0);
        idx = 0;
        for (int i = 0; i < 6; i++) if (ch[i]) idx = i;
        e = '{data: last_data, dv: 1'b0, late: 1'b0};
        if (oh && cl) mvalid[idx] = 1'b0;
        if (oh && !rn) begin
            if (mvalid[idx] && mtag[idx] == tag) begin
                e = '{data: nib(mbyte[idx], s), dv: 1'b1, late: 1'b0};
            end else begin
                addr_q.push_back(tag);
                b = ovr_en ? ovr_byte : rom_byte(tag);
                if (withhold) begin
                    e = '{data: 4'h0, dv: 1'b1, late: 1'b1};
                end else begin
                    e = '{data: nib(b, s), dv: 1'b1, late: 1'b0};
                    mvalid[idx] = 1'b1;
                    mtag[idx]   = tag;
                    mbyte[idx]  = b;
                end
            end
        end
        exp_q.push_back(e);
        last_data = e.data;
        @(negedge clk);
        cur_ch  = ch;
        roe_n   = rn;
        bank    = bk;
        addr_in = ad;
        sel     = s;
        clr     = cl;
        cen     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        @(negedge clk);
        cen    = 1'b0;
        roe_n  = 1'b1;
        clr    = 1'b0;
        cur_ch = '0;
        repeat (P - 2) @(negedge clk);
    endtask

    task automatic slot(input logic [5:0] ch, input bit rn, input logic [4:0] bk,
                        input logic [19:0] ad, input bit s, input bit cl);
        issue(ch, rn, bk, ad, s, cl);
        gap();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [5:0]  ch;
        logic [4:0]  bk;
        logic [19:0] ad;
        int          c;

        repeat (3) @(negedge clk);
        check("rst_cs", 32'(rom_cs), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_out", 32'({data, data_valid, late}), 32'd0);
        model_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First fetch, 3 clk memory latency, then a hit on the other nibble
        fixed_delay = 3;
        ovr_en      = 1'b1;
        ovr_byte    = 8'hA7;
        slot(6'b000001, 1'b0, 5'h03, 20'h00100, 1'b0, 1'b0);
        ovr_en = 1'b0;
        for (int k = 1; k < 6; k++) slot(6'b000001 << k, 1'b1, 5'h00, 20'h0, 1'b0, 1'b0);
        slot(6'b000001, 1'b0, 5'h03, 20'h00100, 1'b1, 1'b0);

        // Restart re-fetches even though the tag matches
        ovr_en   = 1'b1;
        ovr_byte = 8'h5C;
        slot(6'b000001, 1'b0, 5'h03, 20'h00100, 1'b0, 1'b1);
        ovr_en = 1'b0;

        // Deadline miss, then a retry of the same address
        withhold = 1'b1;
        slot(6'b000010, 1'b0, 5'h01, 20'h02345, 1'b0, 1'b0);
        issue(6'b000000, 1'b1, 5'h00, 20'h0, 1'b0, 1'b0);
        withhold = 1'b0;
        check("cs_abort", 32'(rom_cs), 32'd0);
        gap();
        slot(6'b000010, 1'b0, 5'h01, 20'h02345, 1'b1, 1'b0);
        slot(6'b000000, 1'b1, 5'h00, 20'h0, 1'b0, 1'b0);

        // Randomized mix of misses, hits, restarts and idle/multi-hot slots
        fixed_delay = -1;
        for (int i = 0; i < 60; i++) begin
            c  = int'($urandom_range(0, 5));
            ch = 6'b000001 << c;
            if (i % 10 == 9) ch = (i % 20 == 9) ? 6'b000011 : 6'b000000;
            if ((i % 2 == 1) && mvalid[c]) begin
                bk = mtag[c][24:20];
                ad = mtag[c][19:0];
            end else begin
                bk = 5'($urandom);
                ad = 20'($urandom);
            end
            slot(ch, ($urandom_range(0, 7) == 0), bk, ad, 1'($urandom), ($urandom_range(0, 11) == 0));
        end

        // Reset in the middle of a fetch, then a stray rom_ok
        withhold = 1'b1;
        issue(6'b000100, 1'b0, 5'h0A, 20'h0BEEF, 1'b1, 1'b0);
        @(negedge clk);
        cen    = 1'b0;
        roe_n  = 1'b1;
        cur_ch = '0;
        repeat (2) @(negedge clk);
        check("cs_before_rst", 32'(rom_cs), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs", 32'(rom_cs), 32'd0);
        check("rst_mid_addr", 32'(rom_addr), 32'd0);
        check("rst_mid_out", 32'({data, data_valid, late}), 32'd0);
        model_reset();
        withhold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        stray_ok = 1'b1;
        repeat (2) @(negedge clk);
        stray_ok = 1'b0;
        repeat (2) @(negedge clk);
        slot(6'b000100, 1'b0, 5'h0A, 20'h0BEEF, 1'b1, 1'b0);
        slot(6'b000100, 1'b0, 5'h0A, 20'h0BEEF, 1'b0, 1'b0);

        // Final cen consumes the last expectation
        @(negedge clk);
        cen    = 1'b1;
        cur_ch = '0;
        roe_n  = 1'b1;
        @(posedge clk);
        #1;
        gap();
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("addr_drained", 32'(addr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
